moore_seq_generator: RTL and testbench
======================================

Name: moore_seq_generator

Overview:
- Serial pattern transmitter: drives a programmable WIDTH-bit pattern onto a 1-bit serial line X, MSB first, one bit per CLK.
- Supports a programmable repeat count and a programmable number of idle zero bits between repetitions.
- Produces the bit stream that the team's serial sequence detectors consume. The default pattern is 10101.
- Built as an explicit Moore FSM with registered outputs.

Parameters:
- WIDTH, 5, pattern length in bits (≥2).
- PATTERN, 5'b10101, pattern used when USE_PAT=0.
- CNT_W, 8, width of the repeat counter.
- GAP_W, 4, width of the gap counter.

Ports:
- CLK  input  1  system clock, all state changes on posedge.
- R  input  1  synchronous active-high reset.
- START  input  1  request transmission; sampled only when not BUSY.
- USE_PAT  input  1  1: latch PAT at start; 0: latch parameter PATTERN.
- PAT  input  WIDTH  runtime pattern.
- REPEAT  input  CNT_W  number of pattern repetitions; 0 is treated as 1.
- GAP  input  GAP_W  idle (X=0, VALID=0) cycles inserted between repetitions.
- X  output  1  serial data bit (registered).
- VALID  output  1  X carries a pattern bit this cycle.
- BUSY  output  1  transmission in progress.
- DONE  output  1  one-cycle pulse after the final bit.

Behaviour:
- One clock; reset is synchronous and active-high (R sampled on posedge CLK).
- Reset values:
  - Outputs: X=0, VALID=0, BUSY=0, DONE=0.
  - FSM: IDLE.
  - Internal: pat_reg=0, bit_idx=0, rep_left=0, gap_left=0.
- R has priority over every other input. Asserting R mid-transmission aborts immediately with no DONE pulse.
- FSM states:
  - IDLE: BUSY=0, VALID=0, X=0.
    - START=1 at an edge:
      - latch pat_reg (PAT or PATTERN);
      - latch rep_left = (REPEAT==0 ? 1 : REPEAT);
      - latch gap_reg = GAP;
      - set bit_idx = WIDTH-1;
      - go to SEND.
    - In the same edge: X <= selected pattern's MSB, VALID <= 1, BUSY <= 1.
    - Latency: first bit visible in the cycle after the START edge.
  - SEND: each edge advances to the next bit, bit_idx-1, and X <= pat_reg[bit_idx-1].
    - After bit 0 is presented, the next edge:
      - if rep_left>1 and gap_reg>0 → GAP, with gap_left=gap_reg, X=0, VALID=0, rep_left-1;
      - if rep_left>1 and gap_reg==0 → stay in SEND, bit_idx=WIDTH-1, X=MSB, rep_left-1 (back-to-back, no bubble);
      - if rep_left==1 → IDLE, with DONE=1, BUSY=0, VALID=0, X=0.
  - GAP: BUSY=1, VALID=0, X=0 for exactly gap_reg cycles. On the edge ending the last gap cycle → SEND with the MSB presented.
- DONE:
  - High for exactly one cycle, the first IDLE cycle after completion.
  - Cleared on the next edge unless R is asserted.
- START while BUSY=1 is ignored. It is not queued.
- START sampled in the DONE cycle is accepted (back-to-back runs); DONE still deasserts on that edge.
- PAT, REPEAT, GAP and USE_PAT changes while BUSY have no effect on the current run.
- Total BUSY cycles = rep×WIDTH + (rep-1)×GAP, where rep = max(REPEAT,1).
- Counters never wrap. REPEAT = 2^CNT_W-1 is legal.

Test Plan:
- Default pattern: R for 2 cycles; then START=1 for one cycle with USE_PAT=0, REPEAT=1, GAP=0.
  → X=1,0,1,0,1 on cycles 1–5 after the START edge, VALID=1 and BUSY=1 on those cycles; DONE=1 on cycle 6 only; X=0 afterwards.
- Back-to-back repeats: USE_PAT=1, PAT=5'b11010, REPEAT=2, GAP=0.
  → X=1101011010 over 10 contiguous VALID cycles; DONE on cycle 11.
- Gap insertion: PAT=5'b10101, REPEAT=3, GAP=3.
  → 5 bits, 3 cycles X=0/VALID=0/BUSY=1, 5 bits, 3 idle, 5 bits; BUSY high 21 cycles; DONE on cycle 22.
- REPEAT=0 → identical to REPEAT=1 (5 bits then DONE). START pulses during BUSY → ignored, and the bit sequence is unchanged.
- Reset mid-run: R=1 on the 3rd bit of a REPEAT=2 run.
  → next cycle X=0, VALID=0, BUSY=0, DONE=0; a new START then transmits cleanly from the MSB.
- START held high continuously with REPEAT=1, GAP=0 → runs of 5 bits separated by exactly one DONE/IDLE cycle, repeating.

Source files
------------

// File: rtl/moore_seq_generator.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB first with
// programmable repeat count and idle gap, built as a Moore FSM with registered outputs.
module moore_seq_generator #(
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] PATTERN = 5'b10101,
    parameter int               CNT_W   = 8,
    parameter int               GAP_W   = 4
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             START,
    input  logic             USE_PAT,
    input  logic [WIDTH-1:0] PAT,
    input  logic [CNT_W-1:0] REPEAT,
    input  logic [GAP_W-1:0] GAP,
    output logic             X,
    output logic             VALID,
    output logic             BUSY,
    output logic             DONE
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]    MSB_IDX  = BW'(WIDTH - 1);
    localparam logic [BW-1:0]    IDX_ONE  = BW'(1'b1);
    localparam logic [CNT_W-1:0] REP_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1'b1);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1'b1);

    // S_FIN is the one-cycle DONE state; it accepts START exactly like S_IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t           r_state,    w_state;
    logic [WIDTH-1:0] r_pat,      w_pat;
    logic [BW-1:0]    r_bit_idx,  w_bit_idx;
    logic [CNT_W-1:0] r_rep_left, w_rep_left;
    logic [GAP_W-1:0] r_gap_reg,  w_gap_reg;
    logic [GAP_W-1:0] r_gap_left, w_gap_left;
    logic             r_x, r_valid, r_busy, r_done;
    logic             w_x, w_valid, w_busy, w_done;
    logic [WIDTH-1:0] w_sel_pat;

    assign w_sel_pat = USE_PAT ? PAT : PATTERN;

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (R) begin
            r_state    <= S_IDLE;
            r_pat      <= {WIDTH{1'b0}};
            r_bit_idx  <= {BW{1'b0}};
            r_rep_left <= REP_ZERO;
            r_gap_reg  <= GAP_ZERO;
            r_gap_left <= GAP_ZERO;
            r_x        <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_pat      <= w_pat;
            r_bit_idx  <= w_bit_idx;
            r_rep_left <= w_rep_left;
            r_gap_reg  <= w_gap_reg;
            r_gap_left <= w_gap_left;
            r_x        <= w_x;
            r_valid    <= w_valid;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state    = r_state;
        w_pat      = r_pat;
        w_bit_idx  = r_bit_idx;
        w_rep_left = r_rep_left;
        w_gap_reg  = r_gap_reg;
        w_gap_left = r_gap_left;
        case (r_state)
            S_IDLE, S_FIN: begin
                if (START) begin
                    w_state    = S_SEND;
                    w_pat      = w_sel_pat;
                    w_rep_left = (REPEAT == REP_ZERO) ? REP_ONE : REPEAT;
                    w_gap_reg  = GAP;
                    w_bit_idx  = MSB_IDX;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_SEND: begin
                if (r_bit_idx != {BW{1'b0}}) begin
                    w_bit_idx = r_bit_idx - IDX_ONE;
                end else if (r_rep_left > REP_ONE) begin
                    w_rep_left = r_rep_left - REP_ONE;
                    if (r_gap_reg != GAP_ZERO) begin
                        w_state    = S_GAP;
                        w_gap_left = r_gap_reg;
                    end else begin
                        w_bit_idx = MSB_IDX;
                    end
                end else begin
                    w_state = S_FIN;
                end
            end
            S_GAP: begin
                if (r_gap_left == GAP_ONE) begin
                    w_state   = S_SEND;
                    w_bit_idx = MSB_IDX;
                end else begin
                    w_gap_left = r_gap_left - GAP_ONE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they land registered
    always_comb begin
        w_x     = 1'b0;
        w_valid = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (w_state)
            S_SEND: begin
                w_x     = w_pat[w_bit_idx];
                w_valid = 1'b1;
                w_busy  = 1'b1;
            end
            S_GAP: begin
                w_busy = 1'b1;
            end
            S_FIN: begin
                w_done = 1'b1;
            end
            default: begin
                w_done = 1'b0;
            end
        endcase
    end

    assign X     = r_x;
    assign VALID = r_valid;
    assign BUSY  = r_busy;
    assign DONE  = r_done;

endmodule

// File: tb/tb_moore_seq_generator.sv
// Randomized self-checking bench for moore_seq_generator; expected output
// streams are built per run as a queue of {X,VALID,BUSY,DONE} cycles.
module tb_moore_seq_generator;

    logic       CLK = 1'b0;
    logic       R = 1'b1;
    logic       START = 1'b0;
    logic       USE_PAT = 1'b0;
    logic [4:0] PAT = 5'b00000;
    logic [7:0] REPEAT = 8'd1;
    logic [3:0] GAP = 4'd0;
    logic       X, VALID, BUSY, DONE;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] cur = 4'b0000;
    logic [3:0] exp_q[$];
    localparam logic [4:0] DEF_PAT = 5'b10101;

    moore_seq_generator dut (
        .CLK(CLK), .R(R), .START(START), .USE_PAT(USE_PAT), .PAT(PAT),
        .REPEAT(REPEAT), .GAP(GAP), .X(X), .VALID(VALID), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // One clock edge: advance the reference model, then settle past the edge
    task automatic tick();
        logic [4:0] p;
        int rep;
        @(posedge CLK);
        if (R) begin
            exp_q.delete();
            cur = 4'b0000;
        end else if (!cur[1] && START) begin
            p   = USE_PAT ? PAT : DEF_PAT;
            rep = (REPEAT == 8'd0) ? 1 : int'(REPEAT);
            for (int r = 0; r < rep; r++) begin
                for (int b = 4; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b1, 1'b0});
                if (r < rep - 1) begin
                    for (int g = 0; g < int'(GAP); g++) exp_q.push_back(4'b0010);
                end
            end
            exp_q.push_back(4'b0001);
            cur = exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = 4'b0000;
        end
        #1;
    endtask

    task automatic test_reset();
        R = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({X, VALID, BUSY, DONE} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset cyc%0d got xvbd=%b exp=0000", i, {X, VALID, BUSY, DONE});
            end
        end
        R = 1'b0;
    endtask

    task automatic test_default();
        logic [4:0] bits = 5'b00000;
        int nb = 0;
        USE_PAT = 1'b0; PAT = 5'($urandom); REPEAT = 8'd1; GAP = 4'd0; START = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            START = 1'b0;
            if (VALID) begin bits = {bits[3:0], X}; nb++; end
            n_vec++;
            if ({X, VALID, BUSY, DONE} !== cur) begin
                n_err++;
                $display("FAIL default cyc%0d got xvbd=%b exp=%b", i + 1, {X, VALID, BUSY, DONE}, cur);
            end
        end
        n_vec++;
        if (bits !== 5'b10101 || nb != 5) begin
            n_err++;
            $display("FAIL default_bits got %b (%0d bits) exp 10101 (5 bits)", bits, nb);
        end
    endtask

    task automatic test_back_to_back();
        USE_PAT = 1'b1; PAT = 5'b11010; REPEAT = 8'd2; GAP = 4'd0; START = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            START = 1'b0;
            n_vec++;
            if ({X, VALID, BUSY, DONE} !== cur) begin
                n_err++;
                $display("FAIL back_to_back cyc%0d got xvbd=%b exp=%b", i + 1, {X, VALID, BUSY, DONE}, cur);
            end
        end
    endtask

    task automatic test_gap();
        int busy_cnt = 0;
        USE_PAT = 1'b1; PAT = 5'b10101; REPEAT = 8'd3; GAP = 4'd3; START = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            START = 1'b0;
            if (BUSY) busy_cnt++;
            n_vec++;
            if ({X, VALID, BUSY, DONE} !== cur) begin
                n_err++;
                $display("FAIL gap cyc%0d got xvbd=%b exp=%b", i + 1, {X, VALID, BUSY, DONE}, cur);
            end
        end
        n_vec++;
        if (busy_cnt != 3 * 5 + 2 * 3) begin
            n_err++;
            $display("FAIL gap_busy_count got %0d exp %0d", busy_cnt, 3 * 5 + 2 * 3);
        end
    endtask

    task automatic test_repeat_zero_ignore();
        USE_PAT = 1'b1; PAT = 5'($urandom); REPEAT = 8'd0; GAP = 4'd2; START = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            START   = (i < 4) ? 1'($urandom) : 1'b0;
            PAT     = 5'($urandom);
            REPEAT  = 8'($urandom_range(0, 5));
            USE_PAT = 1'($urandom);
            n_vec++;
            if ({X, VALID, BUSY, DONE} !== cur) begin
                n_err++;
                $display("FAIL repeat_zero cyc%0d got xvbd=%b exp=%b", i + 1, {X, VALID, BUSY, DONE}, cur);
            end
        end
    endtask

    task automatic test_reset_mid();
        USE_PAT = 1'b1; PAT = 5'b10011; REPEAT = 8'd2; GAP = 4'd0; START = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            START = (i == 4) ? 1'b1 : 1'b0;
            R     = (i == 2) ? 1'b1 : 1'b0;
            if (i == 3) PAT = 5'b01101;
            n_vec++;
            if ({X, VALID, BUSY, DONE} !== cur) begin
                n_err++;
                $display("FAIL reset_mid cyc%0d got xvbd=%b exp=%b", i + 1, {X, VALID, BUSY, DONE}, cur);
            end
        end
        R = 1'b0;
    endtask

    task automatic test_start_held();
        int dones = 0;
        USE_PAT = 1'b0; REPEAT = 8'd1; GAP = 4'd0; START = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (DONE) dones++;
            n_vec++;
            if ({X, VALID, BUSY, DONE} !== cur) begin
                n_err++;
                $display("FAIL start_held cyc%0d got xvbd=%b exp=%b", i + 1, {X, VALID, BUSY, DONE}, cur);
            end
        end
        START = 1'b0;
        n_vec++;
        if (dones != 4) begin
            n_err++;
            $display("FAIL start_held_dones got %0d exp 4", dones);
        end
    endtask

    task automatic test_max_repeat();
        USE_PAT = 1'b1; PAT = 5'($urandom); REPEAT = 8'd255; GAP = 4'd0; START = 1'b1;
        for (int i = 0; i < 255 * 5 + 3; i++) begin
            tick();
            START = 1'b0;
            n_vec++;
            if ({X, VALID, BUSY, DONE} !== cur) begin
                n_err++;
                $display("FAIL max_repeat cyc%0d got xvbd=%b exp=%b", i + 1, {X, VALID, BUSY, DONE}, cur);
            end
        end
        REPEAT = 8'd2; GAP = 4'd15; START = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            START = 1'b0;
            n_vec++;
            if ({X, VALID, BUSY, DONE} !== cur) begin
                n_err++;
                $display("FAIL max_gap cyc%0d got xvbd=%b exp=%b", i + 1, {X, VALID, BUSY, DONE}, cur);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            START   = ($urandom_range(0, 3) == 0);
            R       = ($urandom_range(0, 149) == 0);
            USE_PAT = 1'($urandom);
            PAT     = 5'($urandom);
            REPEAT  = 8'($urandom_range(0, 4));
            GAP     = 4'($urandom_range(0, 3));
            tick();
            n_vec++;
            if ({X, VALID, BUSY, DONE} !== cur) begin
                n_err++;
                $display("FAIL random cyc%0d got xvbd=%b exp=%b", i, {X, VALID, BUSY, DONE}, cur);
            end
        end
        R = 1'b0; START = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_default();
        test_back_to_back();
        test_gap();
        test_repeat_zero_ignore();
        test_reset_mid();
        test_start_held();
        test_max_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
